// File: rtl/huff_dec_pkg.sv
// Shared constants and the reset-time code tree for the table-driven Huffman decoder.
package huff_dec_pkg;

  localparam logic [1:0] ENT_INVALID = 2'b00;
  localparam logic [1:0] ENT_INT     = 2'b01;
  localparam logic [1:0] ENT_LEAF    = 2'b10;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_INV  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;

  // Payloads of the default tree never exceed 6, so 3 bits carry every value.
  typedef struct packed {
    logic [1:0] typ;
    logic [2:0] pay;
  } dflt_ent_t;

  // Legacy code: 0->1, 100->3, 101->2, 111->4, 1100->6, 1101->5; address = {node, bit}.
  function automatic dflt_ent_t default_entry(input int unsigned addr);
    dflt_ent_t e;
    e = '{ENT_INVALID, 3'd0};
    case (addr)
      0: e = '{ENT_LEAF, 3'd1};
      1: e = '{ENT_INT,  3'd1};
      2: e = '{ENT_INT,  3'd2};
      3: e = '{ENT_INT,  3'd3};
      4: e = '{ENT_LEAF, 3'd3};
      5: e = '{ENT_LEAF, 3'd2};
      6: e = '{ENT_INT,  3'd4};
      7: e = '{ENT_LEAF, 3'd4};
      8: e = '{ENT_LEAF, 3'd6};
      9: e = '{ENT_LEAF, 3'd5};
      default: e = '{ENT_INVALID, 3'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/huff_node_table.sv
// Node table register file: combinational read, one write port, reset-loads the default tree.
module huff_node_table
  import huff_dec_pkg::*;
#(
  parameter int NODES = 8,
  parameter int PAY_W = 3,
  localparam int AW = $clog2(2*NODES),
  localparam int EW = 2 + PAY_W
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr,
  output logic [EW-1:0] rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data
);

  localparam int ENTRIES = 2*NODES;

  logic [EW-1:0] tbl [ENTRIES];

  function automatic logic [EW-1:0] dflt(input int unsigned a);
    dflt_ent_t e;
    e = default_entry(a);
    return {e.typ, PAY_W'(e.pay)};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= dflt(unsigned'(i));
    end else if (we) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-write contents in a write cycle.
  assign rd_data = tbl[rd_addr];

endmodule

// File: rtl/huff_table_decoder.sv
// Serial table-driven Huffman decoder: one bit per handshake, registered symbol/err outputs.
// Optional HUFF_STATS_EN adds saturating sym_count/err_count outputs.
module huff_table_decoder
  import huff_dec_pkg::*;
#(
  parameter int SYM_W   = 3,
  parameter int NODES   = 8,
  parameter int MAX_LEN = 4,
  localparam int NW    = $clog2(NODES),
  localparam int AW    = $clog2(2*NODES),
  localparam int LW    = $clog2(MAX_LEN+1),
  localparam int PAY_W = (SYM_W > NW) ? SYM_W : NW
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [PAY_W+1:0] cfg_data,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [SYM_W-1:0] sym_out,
  output logic [LW-1:0]    sym_len,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             err,
  output logic [1:0]       err_code
`ifdef HUFF_STATS_EN
  ,
  output logic [15:0]      sym_count,
  output logic [15:0]      err_count
`endif
);

  typedef enum logic {ROOT, WALK} walk_t;

  walk_t            state;
  logic [NW-1:0]    node;
  logic [LW-1:0]    depth;
  logic [NW-1:0]    cur_node;
  logic [LW-1:0]    depth_nxt;
  logic [PAY_W+1:0] ent;
  logic [1:0]       ent_type;
  logic [PAY_W-1:0] ent_pay;
  logic             take, is_leaf, is_int, can_descend, produce, err_ev;

  assign cur_node    = (state == ROOT) ? '0 : node;
  assign depth_nxt   = depth + LW'(1);
  assign ent_type    = ent[PAY_W+1:PAY_W];
  assign ent_pay     = ent[PAY_W-1:0];
  assign is_leaf     = (ent_type == ENT_LEAF);
  assign is_int      = (ent_type == ENT_INT);
  assign can_descend = is_int && (depth_nxt < LW'(MAX_LEN));

  assign bit_ready = (!sym_valid || sym_ready) && !flush;
  assign take      = bit_valid && bit_ready;
  assign produce   = take && is_leaf;
  assign err_ev    = take && !is_leaf && !can_descend;

  huff_node_table #(.NODES(NODES), .PAY_W(PAY_W)) u_table (
    .clk     (clk),
    .reset   (reset),
    .rd_addr ({cur_node, bit_in}),
    .rd_data (ent),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ROOT;
      node      <= '0;
      depth     <= '0;
      sym_valid <= 1'b0;
      sym_out   <= '0;
      sym_len   <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      err <= 1'b0;
      // A produced symbol below overrides this clear, so consume+produce keeps valid high.
      if (sym_valid && sym_ready) sym_valid <= 1'b0;
      if (flush) begin
        state <= ROOT;
        node  <= '0;
        depth <= '0;
      end else if (take) begin
        if (is_leaf) begin
          sym_out   <= ent_pay[SYM_W-1:0];
          sym_len   <= depth_nxt;
          sym_valid <= 1'b1;
          state     <= ROOT;
          node      <= '0;
          depth     <= '0;
        end else if (can_descend) begin
          state <= WALK;
          node  <= ent_pay[NW-1:0];
          depth <= depth_nxt;
        end else begin
          err      <= 1'b1;
          err_code <= is_int ? ERR_LEN : ERR_INV;
          state    <= ROOT;
          node     <= '0;
          depth    <= '0;
        end
      end
    end
  end

`ifdef HUFF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_count <= '0;
      err_count <= '0;
    end else begin
      if (produce && sym_count != 16'hFFFF) sym_count <= sym_count + 16'd1;
      if (err_ev && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huff_table_decoder.sv
// Scoreboard bench for huff_table_decoder: directed codes push expectations, a monitor pops on output events.
module tb_huff_table_decoder;
  import huff_dec_pkg::*;

  localparam int SYM_W = 3, NODES = 8, MAX_LEN = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic       flush = 1'b0, cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [4:0] cfg_data = '0;
  logic       bit_in = 1'b0, bit_valid = 1'b0, bit_ready;
  logic [2:0] sym_out, sym_len;
  logic       sym_valid, sym_ready = 1'b1, err;
  logic [1:0] err_code;
`ifdef HUFF_STATS_EN
  logic [15:0] sym_count, err_count;
`endif

  huff_table_decoder #(.SYM_W(SYM_W), .NODES(NODES), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_len(sym_len), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .err(err), .err_code(err_code)
`ifdef HUFF_STATS_EN
    , .sym_count(sym_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int sym; int len; int code; int cyc; } exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic pop_cmp(input int kind, input int s, input int l, input int c);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: kind %0d sym %0d len %0d code %0d at cycle %0d", kind, s, l, c, cyc);
      return;
    end
    e = sbq.pop_front();
    chk("event_kind", kind, e.kind);
    if (e.kind == 0) begin
      chk("sym_out", s, e.sym);
      chk("sym_len", l, e.len);
    end else begin
      chk("err_code", c, e.code);
    end
    if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
  endtask

  // Monitor: a symbol counts once, at its handshake; err is a single-cycle pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (sym_valid && sym_ready) pop_cmp(0, int'(sym_out), int'(sym_len), 0);
      if (err) pop_cmp(1, 0, 0, int'(err_code));
    end
  end

  task automatic send(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  // Sends n bits MSB-first; the expectation is pushed just before the last bit.
  task automatic code(input int n, input logic [7:0] bits, input int kind, input int s,
                      input int l, input int c, input bit timed);
    for (int i = n - 1; i >= 0; i--) begin
      if (i == 0) sbq.push_back('{kind, s, l, c, timed ? cyc + 1 : -1});
      send(bits[i]);
    end
  endtask

  task automatic cfg(input logic [3:0] a, input logic [4:0] d);
    cfg_addr = a; cfg_data = d; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    settle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_out", sym_out, 0);
    chk("rst_sym_len", sym_len, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_bit_ready", bit_ready, 1);

    // Default table, mixed lengths.
    code(1, 8'b0,   0, 1, 1, 0, 1);
    code(3, 8'b100, 0, 3, 3, 0, 1);
    code(3, 8'b101, 0, 2, 3, 0, 1);
    code(3, 8'b111, 0, 4, 3, 0, 1);
    // Maximum-length codes back-to-back.
    code(4, 8'b1100, 0, 6, 4, 0, 1);
    code(4, 8'b1101, 0, 5, 4, 0, 1);
    settle();

    // Backpressure: symbol held, no bits accepted, then consume+produce together.
    sym_ready = 1'b0;
    code(1, 8'b0, 0, 1, 1, 0, 0);
    repeat (5) begin
      chk("hold_bit_ready", bit_ready, 0);
      chk("hold_sym_valid", sym_valid, 1);
      chk("hold_sym_out", sym_out, 1);
      @(posedge clk); #1;
    end
    sym_ready = 1'b1;
    code(1, 8'b0, 0, 1, 1, 0, 1);
    chk("swap_sym_valid", sym_valid, 1);
    settle();

    // Over-length path: node 4 bit 0 now points to node 5 (invalid entries).
    cfg(4'd8,  {ENT_INT, 3'd5});
    cfg(4'd10, {ENT_INVALID, 3'd0});
    cfg(4'd11, {ENT_INVALID, 3'd0});
    do_flush();
    code(4, 8'b1100, 1, 0, 0, 2, 1);
    code(1, 8'b0, 0, 1, 1, 0, 1);
    chk("err_code_held", err_code, 2);
    settle();

    // Invalid root entry, then reset restores the default table.
    cfg(4'd0, {ENT_INVALID, 3'd0});
    code(1, 8'b0, 1, 0, 0, 1, 1);
    chk("inv_no_sym", sym_valid, 0);
    do_reset();
    chk("rst2_err_code", err_code, 0);
    code(1, 8'b0, 0, 1, 1, 0, 1);
    code(4, 8'b1100, 0, 6, 4, 0, 1);

    // Flush mid-code; a bit offered during the flush cycle must be ignored.
    do_reset();
    send(1'b1);
    send(1'b1);
    flush = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
    #1 chk("flush_bit_ready", bit_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; bit_valid = 1'b0;
    code(1, 8'b0, 0, 1, 1, 0, 1);
    settle();
`ifdef HUFF_STATS_EN
    chk("sym_count", sym_count, 1);
    chk("err_count", err_count, 0);
`endif

    settle();
    chk("queue_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huff_table_decoder.md
Name: huff_table_decoder

Overview:
Parametrised, table-driven serial Huffman decoder. It replaces the fixed 6-symbol hardwired tree with a programmable code tree held in a node table. The table reset-loads the legacy code. The block consumes one code bit per accepted handshake, emits decoded symbols through a registered valid/ready output, and flags malformed or over-length codes. It sits between the serial bit source and the symbol consumer in the decode path.

Parameters:
SYM_W, 3, symbol width in bits (>=3 for the default table)
NODES, 8, internal tree nodes (>=5); table holds 2*NODES entries addressed {node, bit}
MAX_LEN, 4, maximum legal code length in bits (>=4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
bit_in  in  1  code bit
bit_valid  in  1  bit_in is valid
bit_ready  out  1  decoder accepts a bit this cycle
sym_out  out  SYM_W  decoded symbol
sym_len  out  $clog2(MAX_LEN+1)  length in bits of the decoded code
sym_valid  out  1  sym_out/sym_len valid
sym_ready  in  1  consumer accepts the symbol
err  out  1  one-cycle error pulse
err_code  out  2  01 = invalid entry, 10 = code exceeds MAX_LEN; held until the next err
flush  in  1  synchronous return of the walk to root
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(2*NODES)  entry address {node, bit}
cfg_data  in  2+PAY_W  entry {type[1:0], payload}; PAY_W = max(SYM_W, $clog2(NODES))

Behaviour:
- Entry type: 00 invalid, 01 internal (payload = child node), 10 leaf (payload = symbol), 11 treated as invalid.
- Reset state:
  - node = 0, depth = 0.
  - sym_valid = 0, sym_out = 0, sym_len = 0, err = 0, err_code = 00.
  - Table reloaded with the default code: 0->1, 100->3, 101->2, 111->4, 1100->6, 1101->5. All other entries invalid.
- bit_ready = (!sym_valid | sym_ready) & !flush.
- A bit is accepted when bit_valid & bit_ready. Table read is combinational on {node, bit_in}. Results are registered at the clock edge:
  - Leaf: sym_out <= payload; sym_len <= depth+1; sym_valid <= 1; node <= 0; depth <= 0. Latency is 1 cycle from the last code bit to sym_valid.
  - Internal and depth+1 < MAX_LEN: node <= payload; depth <= depth+1.
  - Internal and depth+1 == MAX_LEN: err pulse, err_code = 10, node <= 0, depth <= 0.
  - Invalid: err pulse, err_code = 01, node <= 0, depth <= 0.
- The walk state is two states, ROOT (depth = 0) and WALK (depth > 0). A symbol can complete on every accepted bit with no bubble.
- sym_valid clears on sym_ready unless a new leaf is produced in the same cycle. A simultaneous consume and produce keeps sym_valid = 1 and loads the new symbol.
- sym_out and sym_len are stable while sym_valid & !sym_ready.
- flush: node <= 0 and depth <= 0. Any pending symbol is kept. Bits are not accepted during the flush cycle.
- cfg_we writes the entry at the clock edge. A read of the same address in that cycle returns the old value. Writes are allowed mid-walk; software must flush after reprogramming.
- Asynchronous reset mid-code discards the partial code and any pending symbol, and restores the default table.

Optional Feature:
HUFF_STATS_EN:
- Defined: adds outputs sym_count[15:0] and err_count[15:0]. Both increment on each produced symbol or each err pulse, saturate at 16'hFFFF, clear on reset, and are unaffected by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package huff_dec_pkg holds:
  - entry-type constants (ENT_INVALID, ENT_INT, ENT_LEAF);
  - err_code constants;
  - a default-table function returning the entry for a given address.
- One sub-module, huff_node_table: 2*NODES-entry register file with asynchronous combinational read, one write port, and reset-load from the package default function.

Test Plan:
- Default table, stream 0,1,0,0,1,0,1,1,1,1, sym_ready = 1: symbol/length pairs 1/1, 3/3, 2/3, 4/3, each 1 cycle after its last bit; no err.
- Stream 1,1,0,0 then 1,1,0,1 with bit_valid every cycle: 6/4 then 5/4 back-to-back with no bubble.
- Hold sym_ready = 0 after symbol 1: bit_ready = 0, sym_out held at 1 for 5 cycles. Then assert sym_ready with bit_valid and code 0: second symbol 1 is loaded in the same cycle and sym_valid stays 1.
- Program entry {node 4, bit 0} = internal, node 5, with node 5 entries invalid. Stream 1,1,0,0,x: err at bit 4 with err_code = 10 (MAX_LEN = 4). Next stream 0 decodes 1.
- Program {node 0, bit 0} = invalid. Bit 0: err with err_code = 01, no sym_valid. Assert reset: default table restored, bit 0 decodes 1.
- Send bits 1,1, then flush, then 0: decodes symbol 1 (walk restarted at root). With HUFF_STATS_EN, sym_count = 1 and err_count is unchanged.
